// File: rtl/serial_paralelo_pkg.sv
// Shared types and constants for the serial-to-parallel receive path.
package serial_paralelo_pkg;

    localparam int unsigned WORD_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned CCNT_W  = 4;
    localparam int unsigned SEEN_W  = 8;

    // Idle/alignment symbol, shared with the transmitter
    localparam logic [WORD_W-1:0] COMMA_SYM = 8'hBC;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ALIGN = 2'd1,
        SYNC  = 2'd2
    } state_t;

endpackage

// File: rtl/ser_shift_cnt.sv
// Serial shift register and word bit counter for the deserialiser.
module ser_shift_cnt
    import serial_paralelo_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    input  logic              load_align,
    output logic [WORD_W-1:0] nxt,
    output logic              boundary
);

    logic [WORD_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_bit_cnt;

    // Word as it will look once the current bit is shifted in
    assign nxt      = {r_sr[WORD_W-2:0], data_in};
    assign boundary = (r_bit_cnt == CNT_W'(WORD_W - 1));

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sr      <= nxt;
            r_bit_cnt <= load_align ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_paralelo.sv
// Comma-aligned 8-bit deserialiser: hunts for COMMA, qualifies COMMA_COUNT
// aligned commas, then emits data words. COMMA_CNT_EN adds comma_seen_cnt.
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA       = COMMA_SYM,
    parameter int unsigned       COMMA_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
`ifdef COMMA_CNT_EN
    ,
    output logic [SEEN_W-1:0] comma_seen_cnt
`endif
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CCNT_W-1:0]   r_comma_cnt;
    logic [CCNT_W-1:0]   w_comma_cnt_nxt;
    logic [WORD_W-1:0]   r_data_out;
    logic [WORD_W-1:0]   w_data_nxt;
    logic                r_valid_out;
    logic                w_valid_nxt;
    logic                r_active;
    logic                w_load_align;
    logic [WORD_W-1:0]   w_nxt;
    logic                w_boundary;
    logic                w_is_comma;

    ser_shift_cnt u_shift (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .load_align (w_load_align),
        .nxt        (w_nxt),
        .boundary   (w_boundary)
    );

    assign w_is_comma = (w_nxt == COMMA);

    // Alignment FSM and next values of the output registers
    always_comb begin
        w_state_nxt     = r_state;
        w_comma_cnt_nxt = r_comma_cnt;
        w_data_nxt      = r_data_out;
        w_valid_nxt     = r_valid_out;
        w_load_align    = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_is_comma) begin
                    w_load_align    = 1'b1;
                    w_comma_cnt_nxt = CCNT_W'(1);
                    w_state_nxt     = (COMMA_COUNT == 1) ? SYNC : ALIGN;
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_comma_cnt_nxt = r_comma_cnt + CCNT_W'(1);
                        if (w_comma_cnt_nxt == CCNT_W'(COMMA_COUNT)) begin
                            w_state_nxt = SYNC;
                        end
                    end else begin
                        w_comma_cnt_nxt = '0;
                        w_state_nxt     = HUNT;
                    end
                end
            end
            SYNC: begin
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_data_nxt  = w_nxt;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = HUNT;
                w_comma_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= HUNT;
            r_comma_cnt <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_comma_cnt <= w_comma_cnt_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
            r_active    <= (w_state_nxt == SYNC);
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign active    = r_active;

`ifdef COMMA_CNT_EN
    logic [SEEN_W-1:0] r_comma_seen;
    logic [SEEN_W-1:0] w_comma_seen_nxt;

    // Saturating count of idle commas seen once in sync
    always_comb begin
        w_comma_seen_nxt = r_comma_seen;
        if ((r_state == SYNC) && w_boundary && w_is_comma && (r_comma_seen != '1)) begin
            w_comma_seen_nxt = r_comma_seen + SEEN_W'(1);
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_comma_seen <= '0;
        end else begin
            r_comma_seen <= w_comma_seen_nxt;
        end
    end

    assign comma_seen_cnt = r_comma_seen;
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// Scoreboard bench for serial_paralelo: two instances (COMMA_COUNT 4 and 1)
// share one bitstream; a stream-scanning model predicts sync point and words.
module tb_serial_paralelo;
    import serial_paralelo_pkg::*;

    localparam int NDUT = 2;

    typedef struct {
        int         cyc;
        logic [7:0] w;
    } ev_t;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;
    logic data_in = 1'b0;

    logic [NDUT-1:0][7:0] dout;
    logic [NDUT-1:0]      vout;
    logic [NDUT-1:0]      act;
`ifdef COMMA_CNT_EN
    logic [NDUT-1:0][7:0] ccnt;
`endif

    serial_paralelo #(.COMMA(8'hBC), .COMMA_COUNT(4)) u_dut4 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (dout[0]),
        .valid_out (vout[0]),
        .active    (act[0])
`ifdef COMMA_CNT_EN
        ,
        .comma_seen_cnt (ccnt[0])
`endif
    );

    serial_paralelo #(.COMMA(8'hBC), .COMMA_COUNT(1)) u_dut1 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (dout[1]),
        .valid_out (vout[1]),
        .active    (act[1])
`ifdef COMMA_CNT_EN
        ,
        .comma_seen_cnt (ccnt[1])
`endif
    );

    always #5 clk_32f = ~clk_32f;

    ev_t  exp_q [NDUT][$];
    int   exp_sync [NDUT];
    int   exp_cc   [NDUT];
    int   cnt_n    [NDUT] = '{4, 1};
    bit   stim [$];
    int   tests_run = 0;
    int   n_fail    = 0;
    int   cur_edge  = -1;
    bit   mon_en    = 1'b0;

    logic       prev_v  [NDUT];
    logic [7:0] prev_d  [NDUT];
    logic       prev_a  [NDUT];
    int         last_ev [NDUT];
    bit         sync_seen [NDUT];

    task automatic check(input string name, input int got, input int want);
        tests_run++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                     name, got, got, want, want, $time);
        end
    endtask

    // 8-bit window ending at bit i, MSB-first, zeros before the stream start
    function automatic int win(input int i);
        int v = 0;
        for (int j = i - 7; j <= i; j++) begin
            v = (v << 1) | ((j >= 0) ? int'(stim[j]) : 0);
        end
        return v & 255;
    endfunction

    // Scan the stream: find a comma at any bit, then require n-1 more commas
    // in consecutive 8-bit slots; a failed slot resumes the search one bit later.
    task automatic model(input int d);
        int n  = cnt_n[d];
        int sz = stim.size();
        int i  = 0;
        int j;
        int cnt;
        bit done = 1'b0;
        ev_t e;
        exp_sync[d] = -1;
        exp_cc[d]   = 0;
        exp_q[d].delete();
        while (i < sz && !done) begin
            if (win(i) == int'(COMMA_SYM)) begin
                cnt = 1;
                j   = i;
                while (cnt < n && j + 8 < sz && win(j + 8) == int'(COMMA_SYM)) begin
                    j   += 8;
                    cnt++;
                end
                if (cnt == n) begin
                    exp_sync[d] = j;
                    done        = 1'b1;
                end else if (j + 8 >= sz) begin
                    done = 1'b1;
                end else begin
                    i = j + 9;
                end
            end else begin
                i++;
            end
        end
        if (exp_sync[d] >= 0) begin
            for (int k = exp_sync[d] + 8; k < sz; k += 8) begin
                if (win(k) == int'(COMMA_SYM)) begin
                    if (exp_cc[d] < 255) exp_cc[d]++;
                end else begin
                    e.cyc = k;
                    e.w   = 8'(win(k));
                    exp_q[d].push_back(e);
                end
            end
        end
    endtask

    // Monitor: a new word is a valid rise, a data change, or 8 cycles of held valid
    always @(negedge clk_32f) begin : monitor
        ev_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (!mon_en) begin
                prev_v[d]    = 1'b0;
                prev_d[d]    = 8'h00;
                prev_a[d]    = 1'b0;
                last_ev[d]   = -100;
                sync_seen[d] = 1'b0;
            end else begin
                if (act[d] && !prev_a[d]) begin
                    sync_seen[d] = 1'b1;
                    check($sformatf("sync_edge_n%0d", cnt_n[d]), cur_edge, exp_sync[d]);
                end
                if (!act[d] && prev_a[d]) check($sformatf("active_kept_n%0d", cnt_n[d]), 0, 1);
                if (vout[d] && (!prev_v[d] || dout[d] != prev_d[d] || cur_edge - last_ev[d] == 8)) begin
                    last_ev[d] = cur_edge;
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("unexpected_word_n%0d", cnt_n[d]), int'(dout[d]), -1);
                    end else begin
                        e = exp_q[d].pop_front();
                        check($sformatf("word_n%0d", cnt_n[d]), int'(dout[d]), int'(e.w));
                        check($sformatf("word_edge_n%0d", cnt_n[d]), cur_edge, e.cyc);
                    end
                end
                if (prev_v[d] && !vout[d]) begin
                    check($sformatf("hold_on_comma_n%0d", cnt_n[d]), int'(dout[d]), int'(prev_d[d]));
                end
                prev_v[d] = vout[d];
                prev_d[d] = dout[d];
                prev_a[d] = act[d];
            end
        end
    end

    task automatic add_word(input logic [7:0] w);
        for (int b = 7; b >= 0; b--) stim.push_back(w[b]);
    endtask

    task automatic add_rand_bits(input int n);
        for (int b = 0; b < n; b++) stim.push_back(1'($urandom_range(0, 1)));
    endtask

    // Reset asserted between clock edges must clear outputs without a clock
    task automatic async_reset_check();
        @(posedge clk_32f);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_data_out_n%0d", cnt_n[d]), int'(dout[d]), 0);
            check($sformatf("rst_valid_n%0d", cnt_n[d]), int'(vout[d]), 0);
            check($sformatf("rst_active_n%0d", cnt_n[d]), int'(act[d]), 0);
`ifdef COMMA_CNT_EN
            check($sformatf("rst_comma_cnt_n%0d", cnt_n[d]), int'(ccnt[d]), 0);
`endif
        end
    endtask

    task automatic run_scn();
        async_reset_check();
        for (int d = 0; d < NDUT; d++) model(d);
        data_in = stim[0];
        repeat (2) @(negedge clk_32f);
        reset    = 1'b1;
        cur_edge = -1;
        mon_en   = 1'b1;
        for (int k = 0; k < stim.size(); k++) begin
            @(posedge clk_32f);
            #1;
            cur_edge = k;
            data_in  = (k + 1 < stim.size()) ? stim[k + 1] : 1'b0;
        end
        @(negedge clk_32f);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("words_left_n%0d", cnt_n[d]), exp_q[d].size(), 0);
            check($sformatf("sync_reached_n%0d", cnt_n[d]), int'(sync_seen[d]),
                  (exp_sync[d] >= 0) ? 1 : 0);
`ifdef COMMA_CNT_EN
            check($sformatf("comma_seen_n%0d", cnt_n[d]), int'(ccnt[d]), exp_cc[d]);
`endif
        end
        mon_en = 1'b0;
        stim.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk_32f);

        // Acquire sync after a 3-bit skew, then data, data, idle
        add_rand_bits(3);
        repeat (4) add_word(8'hBC);
        add_word(8'hA5);
        add_word(8'h3C);
        add_word(8'hBC);
        add_word(8'h5A);
        run_scn();

        // Broken comma run in ALIGN falls back to HUNT, then reacquires
        add_rand_bits(5);
        add_word(8'hBC);
        add_word(8'hBC);
        add_word(8'h7E);
        repeat (4) add_word(8'hBC);
        add_word(8'h12);
        add_word(8'h34);
        add_word(8'h34);
        add_word(8'h56);
        run_scn();

        // Single comma at bit offset 5, then 0x11
        add_rand_bits(5);
        add_word(8'hBC);
        add_word(8'h11);
        add_word(8'h22);
        add_word(8'h11);
        run_scn();

        // Long idle run in sync to saturate the comma counter
        add_rand_bits(3);
        repeat (304) add_word(8'hBC);
        add_word(8'hC3);
        add_word(8'h0F);
        run_scn();

        // Randomised streams with occasional idle and repeated words
        for (int t = 0; t < 4; t++) begin
            logic [7:0] w;
            add_rand_bits($urandom_range(0, 15));
            repeat (4) add_word(8'hBC);
            for (int k = 0; k < 14; k++) begin
                w = ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom_range(0, 255));
                add_word(w);
                if ($urandom_range(0, 4) == 0) add_word(w);
            end
            run_scn();
        end

        async_reset_check();
        $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
        $finish;
    end

endmodule
